// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the RNBIP-2 3-stage pipeline. Owns the program
// counter, drives the (combinational) program-memory address, and hands each
// fetched word to the first control pipeline register together with its
// evaluated condition flag and the return address (PC+1).
//
// Control-flow hazards are resolved by freezing fetch after any branch, call
// or return. BR_SHADOW NOP bubbles are emitted while the instruction travels
// to the last control stage. That stage then either redirects the PC
// (l_pc=1) or lets fetch resume at branch+1.
//
// Ports
//   clk        in   system clock, all state on posedge
//   rst        in   synchronous active-high reset
//   pm_addr    out  program-memory address (= PC)
//   pm_data    in   instruction word at pm_addr; opcode [15:8], operand [7:0]
//   flags      in   status flags, indexed by the condition field pm_data[10:8]
//   stall      in   fetch hold request (only honoured in RUN)
//   l_pc       in   PC load strobe from the last control stage
//   s11, s10   in   PC-source select: 01 br_od, 11 tgt_reg, 10 tgt_stk, 00 hold
//   tgt_reg    in   register-sourced absolute target
//   tgt_stk    in   return address popped from the stack
//   segment    out  instruction word to the first control stage (NOP = 0)
//   fl         out  condition flag belonging to segment
//   pc_out     out  next PC / return address belonging to segment
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BR_SHADOW = 3
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pm_addr,
    input  logic [15:0]     pm_data,
    input  logic [7:0]      flags,
    input  logic            stall,
    input  logic            l_pc,
    input  logic            s11,
    input  logic            s10,
    input  logic [PC_W-1:0] tgt_reg,
    input  logic [PC_W-1:0] tgt_stk,
    output logic [15:0]     segment,
    output logic            fl,
    output logic [PC_W-1:0] pc_out
);

    localparam int CNT_W = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [7:0]      r_br_od;
    logic [7:0]      w_br_od_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_redirect_tgt;
    logic [7:0]      w_op;
    logic            w_bubble;
    logic            w_cf_op;
    logic            w_cf;

    // Increment wraps naturally at 2^PC_W.
    assign w_pc_inc = r_pc + PC_W'(1);

    // The PC register is still unknown in the very first reset cycle, so the
    // address and return address are forced to their reset values directly.
    assign pm_addr = rst ? RESET_PC : r_pc;
    assign pc_out  = rst ? (RESET_PC + PC_W'(1)) : w_pc_inc;

    // A slot is a bubble during reset, for the whole branch shadow, and while
    // a stall is requested in RUN.
    assign w_bubble = rst || (r_state == ST_WAIT) || stall;

    assign segment = w_bubble ? 16'h0000 : pm_data;
    assign fl      = w_bubble ? 1'b0 : flags[pm_data[10:8]];

    // Control-flow opcode classes: 0000_0011..0000_0111, 0000_1xxx,
    // 0010_1xxx, 0011_xxxx, 0100_1xxx.
    assign w_op    = pm_data[15:8];
    assign w_cf_op = ((w_op[7:3] == 5'b00000) && (w_op[2:0] >= 3'd3)) ||
                     (w_op[7:3] == 5'b00001) ||
                     (w_op[7:3] == 5'b00101) ||
                     (w_op[7:4] == 4'b0011)  ||
                     (w_op[7:3] == 5'b01001);
    assign w_cf    = w_cf_op && !w_bubble;

    // Redirect target; select 00 deliberately keeps the current PC.
    always_comb begin
        w_redirect_tgt = r_pc;
        unique case ({s11, s10})
            2'b01:   w_redirect_tgt = PC_W'(r_br_od);
            2'b11:   w_redirect_tgt = tgt_reg;
            2'b10:   w_redirect_tgt = tgt_stk;
            default: w_redirect_tgt = r_pc;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_br_od_next = r_br_od;
        w_cnt_next   = r_cnt;

        unique case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_pc_next = w_pc_inc;
                    if (w_cf) begin
                        w_br_od_next = pm_data[7:0];
                        w_cnt_next   = CNT_W'(BR_SHADOW);
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // stall is ignored here: the downstream stages keep moving and
                // the shadow must expire on schedule.
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // A redirect overrides both the increment and a stall hold, and
        // terminates any outstanding shadow.
        if (l_pc) begin
            w_pc_next = w_redirect_tgt;
            if (r_state == ST_WAIT) begin
                w_state_next = ST_RUN;
                w_cnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_br_od <= 8'h00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_br_od <= w_br_od_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. The stimulus process drives one cycle at a
// time and pushes the hand-computed expected outputs for that cycle into a
// queue; an independent monitor samples the DUT on the falling edge and
// compares against the head of the queue. Program memory is a bench array
// read combinationally at pm_addr.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [7:0]  pm_addr;
    logic [15:0] pm_data;
    logic [7:0]  flags;
    logic        stall;
    logic        l_pc;
    logic        s11;
    logic        s10;
    logic [7:0]  tgt_reg;
    logic [7:0]  tgt_stk;
    logic [15:0] segment;
    logic        fl;
    logic [7:0]  pc_out;

    logic [15:0] pmem [0:255];

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [15:0] seg;
        logic        fl;
        logic [7:0]  pco;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .PC_W      (8),
        .RESET_PC  (8'h00),
        .BR_SHADOW (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pm_addr (pm_addr),
        .pm_data (pm_data),
        .flags   (flags),
        .stall   (stall),
        .l_pc    (l_pc),
        .s11     (s11),
        .s10     (s10),
        .tgt_reg (tgt_reg),
        .tgt_stk (tgt_stk),
        .segment (segment),
        .fl      (fl),
        .pc_out  (pc_out)
    );

    assign pm_data = pmem[pm_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus plus its expected outputs.
    task automatic cyc(input string nm, input logic [7:0] ea, input logic [15:0] es,
                       input logic ef, input logic rst_v = 1'b0, input logic stall_v = 1'b0,
                       input logic lpc_v = 1'b0, input logic [1:0] sel = 2'b00,
                       input logic [7:0] treg = 8'h00, input logic [7:0] tstk = 8'h00,
                       input logic [7:0] flg = 8'h00);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = rst_v;
        stall   = stall_v;
        l_pc    = lpc_v;
        {s11, s10} = sel;
        tgt_reg = treg;
        tgt_stk = tstk;
        flags   = flg;
        e.name = nm;
        e.addr = ea;
        e.seg  = es;
        e.fl   = ef;
        e.pco  = ea + 8'd1;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle presents an output slot; check it against the
    // oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %-10s pm_addr=%02h segment=%04h fl=%0b pc_out=%02h",
                         e.name, pm_addr, segment, fl, pc_out);
                n_checks++;
                if (pm_addr !== e.addr) begin
                    n_fail++;
                    $display("FAIL %s pm_addr got %02h want %02h", e.name, pm_addr, e.addr);
                end
                n_checks++;
                if (segment !== e.seg) begin
                    n_fail++;
                    $display("FAIL %s segment got %04h want %04h", e.name, segment, e.seg);
                end
                n_checks++;
                if (fl !== e.fl) begin
                    n_fail++;
                    $display("FAIL %s fl got %0b want %0b", e.name, fl, e.fl);
                end
                n_checks++;
                if (pc_out !== e.pco) begin
                    n_fail++;
                    $display("FAIL %s pc_out got %02h want %02h", e.name, pc_out, e.pco);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; l_pc = 1'b0; s11 = 1'b0; s10 = 1'b0;
        tgt_reg = 8'h00; tgt_stk = 8'h00; flags = 8'h00;
        for (int i = 0; i < 256; i++) pmem[i] = 16'h5A03;
        pmem[8'h05] = 16'h0340;  // direct jump
        pmem[8'h10] = 16'h0920;  // conditional branch
        pmem[8'h20] = 16'h8A10;
        pmem[8'h21] = 16'h8A10;
        pmem[8'h50] = 16'h0700;  // return
        pmem[8'h60] = 16'h0600;  // register call
        pmem[8'h71] = 16'h0340;

        //   name         addr   segment   fl rst stl lpc sel    treg   tstk   flags
        // Reset and linear fetch
        cyc("rst0",      8'h00, 16'h0000, 0, 1);
        cyc("rst1",      8'h00, 16'h0000, 0, 1);
        cyc("run00",     8'h00, 16'h5A03, 0);
        cyc("run01",     8'h01, 16'h5A03, 0);
        cyc("run02",     8'h02, 16'h5A03, 0);
        // Redirect in RUN to reach 0x20, then flag select
        cyc("jmp20",     8'h03, 16'h5A03, 0, 0, 0, 1, 2'b11, 8'h20);
        cyc("flag1",     8'h20, 16'h8A10, 1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'h04);
        cyc("flag0",     8'h21, 16'h8A10, 0);
        // Taken direct jump; stall inside the shadow must be ignored
        cyc("jmp05",     8'h22, 16'h5A03, 0, 0, 0, 1, 2'b11, 8'h05);
        cyc("cf0340",    8'h05, 16'h0340, 0);
        cyc("sh1",       8'h06, 16'h0000, 0, 0, 1);
        cyc("sh2",       8'h06, 16'h0000, 0, 0, 1);
        cyc("sh3_tk",    8'h06, 16'h0000, 0, 0, 0, 1, 2'b01);
        // Not-taken conditional
        cyc("tgt40",     8'h40, 16'h5A03, 0, 0, 0, 1, 2'b11, 8'h10);
        cyc("cf0920",    8'h10, 16'h0920, 0);
        cyc("nt1",       8'h11, 16'h0000, 0);
        cyc("nt2",       8'h11, 16'h0000, 0);
        cyc("nt3",       8'h11, 16'h0000, 0);
        cyc("nt_resume", 8'h11, 16'h5A03, 0, 0, 0, 1, 2'b11, 8'h50);
        // Return via stack target
        cyc("rtu",       8'h50, 16'h0700, 0);
        cyc("rtu_b1",    8'h51, 16'h0000, 0);
        cyc("rtu_b2",    8'h51, 16'h0000, 0);
        cyc("rtu_b3",    8'h51, 16'h0000, 0, 0, 0, 1, 2'b10, 8'h00, 8'h33);
        cyc("ret33",     8'h33, 16'h5A03, 0, 0, 0, 1, 2'b11, 8'h60);
        // Call via register target
        cyc("cua",       8'h60, 16'h0600, 0);
        cyc("cua_b1",    8'h61, 16'h0000, 0);
        cyc("cua_b2",    8'h61, 16'h0000, 0);
        cyc("cua_b3",    8'h61, 16'h0000, 0, 0, 0, 1, 2'b11, 8'h7E);
        cyc("cua7e",     8'h7E, 16'h5A03, 0, 0, 0, 1, 2'b11, 8'hFF);
        // Wrap at 0xFF
        cyc("wrapFF",    8'hFF, 16'h5A03, 0);
        cyc("wrap00",    8'h00, 16'h5A03, 0);
        // Stall in RUN holds PC and emits NOPs
        cyc("stall1",    8'h01, 16'h0000, 0, 0, 1);
        cyc("stall2",    8'h01, 16'h0000, 0, 0, 1);
        cyc("rel01",     8'h01, 16'h5A03, 0);
        // Redirect wins over stall; select 00 keeps the PC
        cyc("stl_lpc",   8'h02, 16'h0000, 0, 0, 1, 1, 2'b11, 8'h70);
        cyc("sel00",     8'h70, 16'h5A03, 0, 0, 0, 1, 2'b00);
        cyc("hold70",    8'h70, 16'h5A03, 0);
        // Reset during the second WAIT cycle
        cyc("cf71",      8'h71, 16'h0340, 0);
        cyc("w1",        8'h72, 16'h0000, 0);
        cyc("w2_rst",    8'h00, 16'h0000, 0, 1);
        cyc("post_rst0", 8'h00, 16'h5A03, 0);
        cyc("post_rst1", 8'h01, 16'h5A03, 0);

        // Allow the monitor to drain, with a bound.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
